// File: rtl/skin_map_pingpong_pkg.sv
// Types and default geometry shared by the skin map ping-pong buffer files.
`include "skin_map_defs.vh"

package skin_map_pingpong_pkg;

    localparam int DEF_DATA_W = `SKIN_MAP_DATA_W;
    localparam int DEF_ADDR_W = `SKIN_MAP_ADDR_W;

    typedef enum logic {
        ST_IDLE  = `SKIN_MAP_ST_IDLE,
        ST_CLEAR = `SKIN_MAP_ST_CLEAR
    } state_t;

endpackage

// File: rtl/skin_map_bank.sv
// One map bank: port A read/write with registered read, port B write-only.
module skin_map_bank
    import skin_map_pingpong_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              we_a,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [DATA_W-1:0] wdata_a,
    output logic [DATA_W-1:0] rdata_a,
    input  logic              we_b,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [DATA_W-1:0] wdata_b
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    // Read-before-write on port A; the caller never lets A and B hit one address.
    always_ff @(posedge clk) begin
        if (we_a) mem[addr_a] <= wdata_a;
        if (we_b) mem[addr_b] <= wdata_b;
        rdata_a <= mem[addr_a];
    end

endmodule

// File: rtl/skin_map_defs.vh
// Shared defaults and FSM state encodings for the skin map ping-pong buffer.
`ifndef SKIN_MAP_DEFS_VH
`define SKIN_MAP_DEFS_VH

`define SKIN_MAP_DATA_W   16
`define SKIN_MAP_ADDR_W   11

`define SKIN_MAP_ST_IDLE  1'b0
`define SKIN_MAP_ST_CLEAR 1'b1

`endif

// File: rtl/skin_map_pingpong.sv
// Double-buffered accumulation map: one bank is displayed while the other is
// written/accumulated; a frame-end swap flips roles and clears the new write bank.
module skin_map_pingpong
    import skin_map_pingpong_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic              wr_acc,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              swap,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              disp_bank,
    output logic              busy,
    output logic              overrun
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] clr_cnt, clr_cnt_nxt;
    logic              disp_nxt;
    logic              wbank;
    logic              acc_go, ow_go;

    assign busy   = (state == ST_CLEAR);
    assign wbank  = ~disp_bank;
    assign acc_go = wr_en & wr_acc & ~busy;
    assign ow_go  = wr_en & ~wr_acc & ~busy;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_CLEAR;
            clr_cnt   <= '0;
            disp_bank <= 1'b0;
        end else begin
            state     <= state_nxt;
            clr_cnt   <= clr_cnt_nxt;
            disp_bank <= disp_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        clr_cnt_nxt = clr_cnt;
        disp_nxt    = disp_bank;
        case (state)
            ST_IDLE: begin
                if (swap) begin
                    state_nxt   = ST_CLEAR;
                    clr_cnt_nxt = '0;
                    disp_nxt    = ~disp_bank;
                end
            end
            ST_CLEAR: begin
                clr_cnt_nxt = clr_cnt + ADDR_W'(1);
                if (clr_cnt == LAST) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                        overrun <= 1'b0;
        else if (busy && (wr_en || swap)) overrun <= 1'b1;
    end

    // Accumulate pipeline. S1 holds the request whose cell read is in flight,
    // S2 holds the saturated sum being written, S3 remembers last cycle's write
    // because a read issued in that cycle could not see it yet.
    logic              s1_vld, s1_bank;
    logic [ADDR_W-1:0] s1_addr;
    logic [DATA_W-1:0] s1_inc;
    logic              s2_vld, s2_bank;
    logic [ADDR_W-1:0] s2_addr;
    logic [DATA_W-1:0] s2_sum;
    logic              s3_vld, s3_bank;
    logic [ADDR_W-1:0] s3_addr;
    logic [DATA_W-1:0] s3_sum;

    logic [1:0][DATA_W-1:0] qa;
    logic [DATA_W-1:0]      base, sat_sum;
    logic [DATA_W:0]        wide_sum;
    logic                   kill_s1, kill_s2, s2_we;

    // A newer overwrite to the same cell cancels any older accumulate in flight.
    assign kill_s1 = ow_go && s1_vld && (s1_addr == wr_addr) && (s1_bank == wbank);
    assign kill_s2 = ow_go && s2_vld && (s2_addr == wr_addr) && (s2_bank == wbank);
    assign s2_we   = s2_vld && !kill_s2;

    always_comb begin
        base = qa[s1_bank];
        if (s2_vld && (s2_bank == s1_bank) && (s2_addr == s1_addr))
            base = s2_sum;
        else if (s3_vld && (s3_bank == s1_bank) && (s3_addr == s1_addr))
            base = s3_sum;
    end

    assign wide_sum = {1'b0, base} + {1'b0, s1_inc};
    assign sat_sum  = wide_sum[DATA_W] ? {DATA_W{1'b1}} : wide_sum[DATA_W-1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_vld  <= 1'b0;
            s1_bank <= 1'b0;
            s1_addr <= '0;
            s1_inc  <= '0;
            s2_vld  <= 1'b0;
            s2_bank <= 1'b0;
            s2_addr <= '0;
            s2_sum  <= '0;
            s3_vld  <= 1'b0;
            s3_bank <= 1'b0;
            s3_addr <= '0;
            s3_sum  <= '0;
        end else begin
            s1_vld  <= acc_go;
            s1_bank <= wbank;
            s1_addr <= wr_addr;
            s1_inc  <= wr_data;
            s2_vld  <= s1_vld && !kill_s1;
            s2_bank <= s1_bank;
            s2_addr <= s1_addr;
            s2_sum  <= sat_sum;
            s3_vld  <= s2_we;
            s3_bank <= s2_bank;
            s3_addr <= s2_addr;
            s3_sum  <= s2_sum;
        end
    end

    // Port A serves the display read or, on the write bank, clear/overwrite/
    // accumulate-read; port B only drains S2, possibly into the now-display bank.
    for (genvar b = 0; b < 2; b++) begin : g_bank
        logic              is_wr, we_a, we_b;
        logic [ADDR_W-1:0] addr_a;
        logic [DATA_W-1:0] wdata_a;

        assign is_wr   = (wbank == 1'(b));
        assign addr_a  = !is_wr ? rd_addr : (busy ? clr_cnt : wr_addr);
        assign we_a    = is_wr && (busy || ow_go);
        assign wdata_a = busy ? '0 : wr_data;
        assign we_b    = s2_we && (s2_bank == 1'(b));

        skin_map_bank #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W)
        ) u_bank (
            .clk     (clk),
            .we_a    (we_a),
            .addr_a  (addr_a),
            .wdata_a (wdata_a),
            .rdata_a (qa[b]),
            .we_b    (we_b),
            .addr_b  (s2_addr),
            .wdata_b (s2_sum)
        );
    end

    logic rd_sel, rd_ok;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_sel <= 1'b0;
            rd_ok  <= 1'b0;
        end else begin
            rd_sel <= disp_bank;
            rd_ok  <= 1'b1;
        end
    end

    assign rd_data = rd_ok ? qa[rd_sel] : '0;

endmodule

// File: tb/tb_skin_map_pingpong.sv
// Directed bench for skin_map_pingpong at DATA_W=9, ADDR_W=4 (16-word banks).
module tb_skin_map_pingpong;

    localparam int DW = 9;
    localparam int AW = 4;

    logic          clk = 1'b0, reset = 1'b1;
    logic          wr_en = 1'b0, wr_acc = 1'b0, swap = 1'b0;
    logic [AW-1:0] wr_addr = '0, rd_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic [DW-1:0] rd_data;
    logic          disp_bank, busy, overrun;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    skin_map_pingpong #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (wr_en),
        .wr_acc    (wr_acc),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .swap      (swap),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .disp_bank (disp_bank),
        .busy      (busy),
        .overrun   (overrun)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic acc, input int a, input int d);
        wr_en   = 1'b1;
        wr_acc  = acc;
        wr_addr = AW'(a);
        wr_data = DW'(d);
        tick();
    endtask

    task automatic idle();
        wr_en  = 1'b0;
        wr_acc = 1'b0;
        swap   = 1'b0;
    endtask

    task automatic pulse_swap();
        swap = 1'b1;
        tick();
        swap = 1'b0;
    endtask

    task automatic busy_len(output int n);
        n = 0;
        while (busy && n < 64) begin
            n++;
            tick();
        end
    endtask

    task automatic rd(input int a, input int exp, input string tag);
        rd_addr = AW'(a);
        tick();
        chk(tag, rd_data, exp);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running, expected finish");
        $fatal(1);
    end

    initial begin
        int n;

        // reset state and post-reset clear of bank 1
        repeat (3) tick();
        chk("rst_busy", busy, 1);
        chk("rst_disp", disp_bank, 0);
        chk("rst_ovr", overrun, 0);
        chk("rst_rd", rd_data, 0);
        reset = 1'b0;
        busy_len(n);
        chk("rst_busy_len", n, 16);
        rd(3, 0, "bank0_rd");

        // five back-to-back accumulates of 3
        for (int i = 0; i < 5; i++) req(1'b1, 7, 3);
        idle();
        pulse_swap();
        chk("swap1_disp", disp_bank, 1);
        chk("swap1_busy", busy, 1);
        busy_len(n);
        chk("swap1_busy_len", n, 16);
        rd(7, 15, "acc_x5");
        chk("ovr_clean", overrun, 0);

        // saturation: 200 + 200 + 200 clips at 511
        for (int i = 0; i < 3; i++) req(1'b1, 2, 200);
        idle();
        pulse_swap();
        chk("swap2_disp", disp_bank, 0);
        busy_len(n);
        chk("swap2_idle", busy, 0);
        rd(2, 511, "acc_sat");

        // forwarding across a gap, overwrite/accumulate ordering
        req(1'b1, 6, 5);
        idle();
        tick();
        req(1'b1, 6, 5);
        req(1'b0, 4, 'h55);
        req(1'b1, 4, 1);
        req(1'b1, 5, 1);
        req(1'b0, 5, 'h10);
        idle();
        tick();
        rd_addr = 4'd2;
        pulse_swap();
        chk("swap_cycle_rd_old", rd_data, 511);
        rd(4, 'h56, "ow_then_acc");
        rd(5, 'h10, "acc_then_ow");
        rd(6, 10, "acc_gap");
        busy_len(n);
        chk("swap3_idle", busy, 0);

        // swap during clear is ignored; write during clear is dropped
        pulse_swap();
        chk("swap4_disp", disp_bank, 0);
        tick();
        tick();
        pulse_swap();
        chk("swap_ignored_disp", disp_bank, 0);
        chk("swap_ignored_ovr", overrun, 1);
        req(1'b0, 1, 'h33);
        idle();
        busy_len(n);
        chk("swap4_idle", busy, 0);
        chk("disp_once", disp_bank, 0);

        // fill bank 1, start clearing bank 0, reset at clear count 8
        req(1'b0, 12, 'h77);
        req(1'b0, 0, 'h77);
        idle();
        pulse_swap();
        chk("swap5_disp", disp_bank, 1);
        rd(1, 0, "dropped_wr");
        rd(12, 'h77, "b1_pre_rst");
        repeat (6) tick();
        chk("ovr_sticky", overrun, 1);
        reset = 1'b1;
        tick();
        chk("mid_rst_busy", busy, 1);
        chk("mid_rst_disp", disp_bank, 0);
        chk("mid_rst_ovr", overrun, 0);
        tick();
        reset = 1'b0;
        busy_len(n);
        chk("mid_rst_busy_len", n, 16);
        pulse_swap();
        chk("swap6_disp", disp_bank, 1);
        for (int a = 0; a < 16; a++) rd(a, 0, "b1_cleared");
        busy_len(n);
        chk("final_idle", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
